// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if -- word handshake into serial_frame_tx.
//
// Handshake: a word transfers on every clk edge where in_valid && in_ready
// are both 1. The master holds in_data/in_valid stable until that edge.
// in_ready is a pure function of the receiver's FIFO occupancy and does not
// depend on in_valid.
//
// Signals:
//   in_data   WIDTH  word to transmit           (master -> slave)
//   in_valid  1      in_data valid              (master -> slave)
//   in_ready  1      receiver can take a word   (slave -> master)
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx -- buffers WIDTH-bit words in a DEPTH-entry FIFO and
// shifts them out MSB-first, one bit per bit_en strobe, with no gap bit
// between consecutive frames while words are queued.
//
// Build option: define SER_PARITY_EN to append an even-parity bit to each
// frame (frame becomes WIDTH+1 bits). Undefined: WIDTH-bit frames.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   in_bus       slave side of serial_frame_tx_if (in_data/in_valid/in_ready)
//   bit_en       bit-rate strobe; the shifter only moves on bit_en=1 cycles
//   ser_out      registered serial bit
//   ser_valid    ser_out carries a frame bit
//   frame_start  one-clk pulse when ser_out first shows a word's MSB
//   busy         shifter active or FIFO non-empty
//   fifo_count   words held in the FIFO
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    serial_frame_tx_if.slave           in_bus,
    input  logic                       bit_en,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       frame_start,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop, fifo_empty;

    assign in_bus.in_ready = (count != CW'(DEPTH));
    assign push            = in_bus.in_valid && in_bus.in_ready;
    assign fifo_empty      = (count == '0);
    assign fifo_count      = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_bus.in_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- shifter ----------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             end_frame;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        rem_d         = rem_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;       // pulse: only the load edge sets it
        pop           = 1'b0;
        end_frame     = 1'b0;

        if (bit_en) begin
            case (state_q)
                IDLE: end_frame = 1'b1;
                SHIFT: begin
                    if (rem_q != '0) begin
                        // shreg holds the whole word; rem selects the bit on the line
                        ser_out_d = shreg_q[rem_q - 1'b1];
                        rem_d     = rem_q - 1'b1;
                    end else begin
`ifdef SER_PARITY_EN
                        state_d     = PARITY;
                        ser_out_d   = ^shreg_q;
                        ser_valid_d = 1'b1;
`else
                        end_frame = 1'b1;
`endif
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: end_frame = 1'b1;
`endif
                default: state_d = IDLE;
            endcase

            // Frame boundary (or idle): load the head word with no gap bit,
            // otherwise drop the line and idle.
            if (end_frame) begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    shreg_d       = mem[rd_ptr];
                    ser_out_d     = mem[rd_ptr][WIDTH-1];
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    rem_d         = RW'(WIDTH - 1);
                    state_d       = SHIFT;
                end else begin
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            rem_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            rem_q         <= rem_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx -- directed self-checking bench for serial_frame_tx
// (WIDTH=8, DEPTH=4). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. they reflect that edge.
module tb_serial_frame_tx;
`ifdef SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       ser_out, ser_valid, frame_start, busy;
    logic [2:0] fifo_count;
    int         checks = 0;
    int         errors = 0;

    serial_frame_tx_if #(.WIDTH(8)) bus ();

    serial_frame_tx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bus      (bus),
        .bit_en      (bit_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Bit k of a frame carrying word w: MSB first, parity (if any) last.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < 8) return w[7-k];
        return ^w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ser_out, ser_valid, frame_start, busy, fifo_count, bus.in_ready} !== {4'b0000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: got out/val/fs/busy/cnt/rdy=%b%b%b%b/%0d/%b want 0000/0/1",
                     ser_out, ser_valid, frame_start, busy, fifo_count, bus.in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({ser_out, ser_valid, busy, fifo_count, bus.in_ready} !== {3'b000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: got out/val/busy/cnt/rdy=%b%b%b/%0d/%b want 000/0/1",
                     ser_out, ser_valid, busy, fifo_count, bus.in_ready);
        end
    endtask

    task automatic test_single(input logic [7:0] word);
        bit_en = 1'b1;
        bus.in_data  = word;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({ser_valid, fifo_count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_push %h: got val=%b cnt=%0d want val=0 cnt=1", word, ser_valid, fifo_count);
        end
        for (int k = 0; k < FL; k++) begin
            step();
            checks++;
            if ({ser_out, ser_valid, frame_start} !== {exp_bit(word, k), 1'b1, (k == 0)}) begin
                errors++;
                $display("FAIL single_bit %h[%0d]: got out/val/fs=%b%b%b want %b1%b",
                         word, k, ser_out, ser_valid, frame_start, exp_bit(word, k), (k == 0));
            end
        end
        step();
        checks++;
        if ({ser_out, ser_valid, frame_start, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL single_end %h: got out/val/fs/busy=%b%b%b%b want 0000",
                     word, ser_out, ser_valid, frame_start, busy);
        end
        bit_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        int         total;
        w[0] = 8'hD3;
        w[1] = 8'hFF;
        w[2] = 8'h00;
        total = 3 * FL;
        bit_en = 1'b1;
        for (int k = -1; k < total; k++) begin
            if (k + 1 < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[k+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (k >= 0) begin
                checks++;
                if ({ser_out, ser_valid, frame_start} !== {exp_bit(w[k/FL], k % FL), 1'b1, (k % FL == 0)}) begin
                    errors++;
                    $display("FAIL b2b_bit %0d: got out/val/fs=%b%b%b want %b1%b",
                             k, ser_out, ser_valid, frame_start, exp_bit(w[k/FL], k % FL), (k % FL == 0));
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if ({ser_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got val/busy=%b%b want 00", ser_valid, busy);
        end
        bit_en = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] w [5];
        w[0] = 8'h11;
        w[1] = 8'h22;
        w[2] = 8'h3C;
        w[3] = 8'h81;
        w[4] = 8'hE7;
        bit_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            step();
        end
        checks++;
        if ({fifo_count, bus.in_ready, ser_valid} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_after4: got cnt/rdy/val=%0d/%b/%b want 4/0/0", fifo_count, bus.in_ready, ser_valid);
        end
        bus.in_data = w[4];
        step();
        checks++;
        if ({fifo_count, bus.in_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_hold5: got cnt/rdy=%0d/%b want 4/0", fifo_count, bus.in_ready);
        end
        bit_en = 1'b1;
        step();
        checks++;
        if ({fifo_count, bus.in_ready, ser_out, ser_valid, frame_start} !== {3'd3, 1'b1, exp_bit(w[0], 0), 2'b11}) begin
            errors++;
            $display("FAIL full_pop: got cnt/rdy/out/val/fs=%0d/%b/%b%b%b want 3/1/%b11",
                     fifo_count, bus.in_ready, ser_out, ser_valid, frame_start, exp_bit(w[0], 0));
        end
        bit_en = 1'b0;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({fifo_count, bus.in_ready, ser_out, ser_valid, frame_start} !== {3'd4, 1'b0, exp_bit(w[0], 0), 2'b10}) begin
            errors++;
            $display("FAIL full_accept5: got cnt/rdy/out/val/fs=%0d/%b/%b%b%b want 4/0/%b10",
                     fifo_count, bus.in_ready, ser_out, ser_valid, frame_start, exp_bit(w[0], 0));
        end
        bit_en = 1'b1;
        for (int k = 1; k < 5 * FL; k++) begin
            step();
            checks++;
            if ({ser_out, ser_valid, frame_start} !== {exp_bit(w[k/FL], k % FL), 1'b1, (k % FL == 0)}) begin
                errors++;
                $display("FAIL full_drain %0d: got out/val/fs=%b%b%b want %b1%b",
                         k, ser_out, ser_valid, frame_start, exp_bit(w[k/FL], k % FL), (k % FL == 0));
            end
        end
        step();
        checks++;
        if ({ser_valid, busy, fifo_count} !== {2'b00, 3'd0}) begin
            errors++;
            $display("FAIL full_end: got val/busy/cnt=%b%b/%0d want 00/0", ser_valid, busy, fifo_count);
        end
        bit_en = 1'b0;
    endtask

    task automatic test_strobe();
        logic [7:0] word;
        int         s;
        logic       strobe;
        word = 8'hA5;
        s = 0;
        bit_en = 1'b0;
        bus.in_data  = word;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 200 && s <= FL; c++) begin
            strobe = ((c % 3) == 0);
            bit_en = strobe;
            if (strobe) s++;
            step();
            checks++;
            if (s <= FL) begin
                if ({ser_out, ser_valid, frame_start} !== {exp_bit(word, s - 1), 1'b1, (strobe && s == 1)}) begin
                    errors++;
                    $display("FAIL strobe_bit c%0d: got out/val/fs=%b%b%b want %b1%b",
                             c, ser_out, ser_valid, frame_start, exp_bit(word, s - 1), (strobe && s == 1));
                end
            end else begin
                if ({ser_out, ser_valid, frame_start, busy} !== 4'b0000) begin
                    errors++;
                    $display("FAIL strobe_end c%0d: got out/val/fs/busy=%b%b%b%b want 0000",
                             c, ser_out, ser_valid, frame_start, busy);
                end
            end
        end
        bit_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD3;
        step();
        bus.in_data  = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_out, ser_valid, frame_start, busy, fifo_count, bus.in_ready} !== {4'b0000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got out/val/fs/busy/cnt/rdy=%b%b%b%b/%0d/%b want 0000/0/1",
                     ser_out, ser_valid, frame_start, busy, fifo_count, bus.in_ready);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if ({ser_valid, busy, fifo_count} !== {2'b00, 3'd0}) begin
                errors++;
                $display("FAIL reset_mid_after c%0d: got val/busy/cnt=%b%b/%0d want 00/0",
                         c, ser_valid, busy, fifo_count);
            end
        end
        bit_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(8'hD3);
        test_single(8'h03);
        test_back_to_back();
        test_full();
        test_strobe();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Upstream feeder for the serial pattern-detector stage.
- Accepts WIDTH-bit words over a valid/ready interface and buffers them in a small FIFO.
- Serialises each word MSB-first as a one-bit stream, advancing one bit per bit_en strobe.
- Provides ser_valid and frame_start qualifiers so the downstream detector sees a gap-free bit stream while data is available.

Parameters:
- WIDTH, 8, bits per word (frame length without parity); must be ≥2.
- DEPTH, 4, FIFO depth in words; must be a power of 2, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  word to transmit
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a word (fifo_count < DEPTH)
- bit_en  input  1  bit-rate strobe; shifter advances only on cycles with bit_en=1
- ser_out  output  1  serial bit, registered
- ser_valid  output  1  ser_out carries a frame bit
- frame_start  output  1  one-clk pulse in the cycle ser_out first presents bit WIDTH-1 of a word
- busy  output  1  shifter not IDLE or FIFO non-empty
- fifo_count  output  $clog2(DEPTH+1)  words held in the FIFO

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, state IDLE.
  - ser_out=0, ser_valid=0, frame_start=0, busy=0, fifo_count=0, in_ready=1.
  - Reset mid-frame discards the partial frame and all queued words.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only by the shifter load.
  - Simultaneous push and pop: count unchanged, both take effect.
  - in_ready is combinational from count; when full it is 0 and in_valid is ignored.
  - Pointers wrap modulo DEPTH.
- Shifter FSM: states IDLE, SHIFT (plus PARITY with the optional feature). Bit counter rem runs 0..WIDTH-1. Transitions occur only on bit_en=1 cycles.
  - IDLE, FIFO non-empty: pop head into shift register; ser_out<=word[WIDTH-1], ser_valid<=1, frame_start<=1, rem<=WIDTH-1; go to SHIFT.
  - IDLE, FIFO empty: stay in IDLE; ser_out=0, ser_valid=0.
  - SHIFT, rem>0: ser_out<=next lower bit, rem<=rem-1.
  - SHIFT, rem=0, FIFO non-empty: load the next word exactly as from IDLE (back-to-back, no gap bit).
  - SHIFT, rem=0, FIFO empty: ser_out<=0, ser_valid<=0; go to IDLE.
- Output timing and hold:
  - With bit_en=0, all state and ser_out/ser_valid hold their values.
  - frame_start is 0 on every cycle except the load cycle's next edge, so it is exactly 1 clk wide regardless of bit_en spacing.
- Latency:
  - A word pushed at edge N is eligible for load on the first bit_en=1 cycle after edge N.
  - Its first bit appears on ser_out at the edge ending that cycle.
  - A word pushed into an empty FIFO while in SHIFT is picked up at that frame's last bit with no gap.
- busy = (state!=IDLE) || (fifo_count!=0).

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After rem=0 in SHIFT on a bit_en cycle, go to PARITY with ser_out<=^word (even parity over the latched word), ser_valid=1.
  - On the next bit_en cycle, PARITY follows the same load/idle rules as SHIFT rem=0.
  - Frame is WIDTH+1 bits.
- When undefined: the PARITY state and logic are absent; frame is WIDTH bits.

Test Plan:
- Reset mid-frame: push 8'hD3, assert rst after 3 bits → same cycle ser_valid=0, ser_out=0, fifo_count=0, in_ready=1; no further bits after release.
- Single word, bit_en=1 constant: push 8'hD3 into empty block → ser_out 1,1,0,1,0,0,1,1 on 8 consecutive cycles with ser_valid=1; frame_start=1 on the first bit only; ser_valid=0 and busy=0 afterwards.
- Back-to-back: push 8'hD3, 8'hFF, 8'h00 consecutively, bit_en=1 → 24 contiguous valid bits; frame_start at bits 0, 8, 16; no ser_valid gap.
- Full FIFO: bit_en=0, present 5 words → in_ready=0 after the 4th push, fifo_count=4, 5th held; raise bit_en → one pop, 5th word accepted, count back to 4.
- Strobe spacing: bit_en high every 3rd cycle, word 8'hA5 → each bit held exactly 3 clks; frame_start 1 clk wide.
- SER_PARITY_EN defined: push 8'hD3 (five 1s) → 9-bit frame 1,1,0,1,0,0,1,1,1. Push 8'h03 → parity bit 0.
